// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle control sequencer for an RV32I core. It fetches one instruction
// over a req/ack memory interface, holds it in the instruction register for the
// decode/control unit, and walks the datapath through FETCH, DECODE, EXECUTE
// and WRITEBACK. It owns the PC and the retired-instruction counter. An
// unsupported opcode or a fetch timeout sends the core to an absorbing HALT
// state, which only rst_i can leave.
//
// Ports
//   clk_i         single clock, rising edge
//   rst_i         synchronous, active-high reset
//   run_i         run enable, sampled only in IDLE and WRITEBACK
//   imem_req_o    fetch request, high in every FETCH cycle
//   imem_addr_o   fetch address (always equal to pc_o)
//   imem_ack_i    fetch data valid; imem_rdata_i is captured in the same cycle
//   imem_rdata_i  fetched instruction word
//   instr_o       instruction register, to the control unit
//   ir_valid_o    instruction register holds a live instruction
//   rf_we_o       register-file write strobe (WRITEBACK only, never for x0)
//   pc_o          current PC
//   state_o       FSM state, for debug
//   instret_o     retired-instruction counter
//   illegal_o     sticky: unsupported opcode seen
//   bus_err_o     sticky: fetch timed out
//   halted_o      core is in HALT
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      instr_o,
    output logic             ir_valid_o,
    output logic             rf_we_o,
    output logic [31:0]      pc_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic             halted_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;

    // Counter value seen in the last FETCH cycle allowed without an ack.
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 32'd1);

    logic [2:0]       state_q,   state_d;
    logic [7:0]       tmo_q,     tmo_d;
    logic [31:0]      pc_q,      pc_d;
    logic [31:0]      instr_q,   instr_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic             opcode_legal_s;
    logic             tmo_expired_s;
    logic             req_s;
    logic             ir_valid_s;
    logic             rf_we_s;
    logic             halted_s;

    assign opcode_legal_s = (instr_q[6:0] == OP_ALU_R) || (instr_q[6:0] == OP_ALU_I);
    // True in the FETCH cycle where a missing ack makes the wait reach FETCH_TIMEOUT.
    assign tmo_expired_s  = (tmo_q == TMO_LAST);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; an ack in the final allowed FETCH cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    state_d = S_DECODE;
                end else if (tmo_expired_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (opcode_legal_s) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                if (run_i) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase
    end

    // FSM outputs, decoded from the state register (and the held rd field) only.
    always_comb begin
        req_s      = 1'b0;
        ir_valid_s = 1'b0;
        rf_we_s    = 1'b0;
        halted_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_s = 1'b0;
            end
            S_FETCH: begin
                req_s = 1'b1;
            end
            S_DECODE, S_EXECUTE: begin
                ir_valid_s = 1'b1;
            end
            S_WRITEBACK: begin
                ir_valid_s = 1'b1;
                // x0 is hardwired to zero, so never strobe a write to it.
                rf_we_s    = (instr_q[11:7] != 5'd0);
            end
            S_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                halted_s = 1'b0;
            end
        endcase
    end

    // Datapath next-state: instruction capture, timeout count, PC, counters, sticky flags.
    always_comb begin
        tmo_d     = tmo_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    tmo_d   = 8'd0;
                end else if (tmo_expired_s) begin
                    bus_err_d = 1'b1;
                    tmo_d     = 8'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (opcode_legal_s) begin
                    illegal_d = illegal_q;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            S_WRITEBACK: begin
                // Both wrap naturally at their register widths.
                pc_d      = pc_q + 32'd4;
                instret_d = instret_q + CNT_W'(1);
            end
            default: begin
                tmo_d = tmo_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q     <= 8'd0;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign imem_req_o  = req_s;
    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign ir_valid_o  = ir_valid_s;
    assign rf_we_o     = rf_we_s;
    assign pc_o        = pc_q;
    assign state_o     = state_q;
    assign instret_o   = instret_q;
    assign illegal_o   = illegal_q;
    assign bus_err_o   = bus_err_q;
    assign halted_o    = halted_s;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Fetches an instruction over a req/ack instruction-memory interface and holds it in an instruction register that feeds the decode/control unit.
- Steps the datapath through fetch, decode, execute and writeback, and owns the PC.
- Supports R-type ALU (opcode 0110011) and I-type ALU (opcode 0010011). Any other opcode, or a fetch timeout, halts the core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be 4-byte aligned).
- FETCH_TIMEOUT, 16, cycles FETCH waits for imem_ack_i before a bus error; legal range 1..255.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- run_i  in  1  enable; sampled in IDLE and WRITEBACK.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address, equal to pc_o.
- imem_ack_i  in  1  fetch data valid; imem_rdata_i is taken in the same cycle.
- imem_rdata_i  in  32  fetched instruction.
- instr_o  out  32  instruction register, to the control unit.
- ir_valid_o  out  1  high in DECODE, EXECUTE and WRITEBACK.
- rf_we_o  out  1  register-file write strobe.
- pc_o  out  32  current PC.
- state_o  out  3  FSM state, for debug.
- instret_o  out  CNT_W  count of retired instructions.
- illegal_o  out  1  sticky: unsupported opcode.
- bus_err_o  out  1  sticky: fetch timeout.
- halted_o  out  1  high in HALT.

Behaviour:
- Clock and reset: one clock domain, clk_i. rst_i is synchronous and active-high.
- Reset values: state = IDLE, pc_o = RESET_PC, instr_o = 0, instret_o = 0. All 1-bit outputs are 0. Timeout counter = 0.
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, WRITEBACK = 4, HALT = 5. Encodings 6 and 7 go to HALT on the next cycle.
- IDLE:
  - run_i = 1 -> FETCH.
  - run_i = 0 -> stay in IDLE.
- FETCH:
  - imem_req_o = 1 and imem_addr_o = pc_o for every FETCH cycle, including the first.
  - imem_ack_i = 1 -> latch imem_rdata_i into instr_o, clear the timeout counter, go to DECODE.
  - Otherwise increment the timeout counter. When the counter reaches FETCH_TIMEOUT with no ack -> set bus_err_o, go to HALT.
  - An ack arriving in the cycle the counter reaches FETCH_TIMEOUT counts as a successful fetch (ack wins).
- DECODE:
  - opcode (instr_o[6:0]) is 0110011 or 0010011 -> EXECUTE.
  - Any other opcode -> set illegal_o, go to HALT. pc_o stays at the faulting instruction.
- EXECUTE: exactly one cycle for the combinational ALU -> WRITEBACK.
- WRITEBACK:
  - rf_we_o = 1 for this single cycle, except rf_we_o = 0 when rd (instr_o[11:7]) = 0, because x0 is never written.
  - pc_o <= pc_o + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - instret_o <= instret_o + 1, wrapping at 2^CNT_W. Writes to x0 still count as retired.
  - Next state: run_i = 1 -> FETCH; run_i = 0 -> IDLE.
- HALT:
  - Absorbing state; only rst_i leaves it.
  - imem_req_o = 0, rf_we_o = 0.
  - halted_o = 1; illegal_o and bus_err_o keep their values.
- run_i outside IDLE/WRITEBACK: ignored. Deasserting run_i never aborts an instruction already in progress.
- Throughput: with ack in the first FETCH cycle, each instruction takes 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK). Each cycle of ack delay adds one cycle.
- Reset mid-operation: rst_i in any state, including HALT or FETCH with req asserted, restores all reset values on the next edge. imem_req_o is 0 in the cycle after the reset edge.
- All outputs are registered or decoded from state only. No output depends combinationally on imem_ack_i.

Test Plan:
1. Reset, then run_i = 1, memory acks immediately with 0x002081B3 (add x3, x1, x2) -> states 0,1,2,3,4,1; rf_we_o pulses once in WRITEBACK; pc_o 0 -> 4; instret_o = 1.
2. I-type addi x0, x0, 5 (0x00500013) -> rf_we_o stays 0 in WRITEBACK; pc_o += 4; instret_o increments.
3. Fetch returns 0x0000006F (JAL) -> illegal_o = 1 and halted_o = 1 from the cycle after DECODE; pc_o unchanged; no imem_req_o afterwards; rst_i then clears all of it.
4. FETCH_TIMEOUT = 4, no ack -> imem_req_o high for 4 cycles, then bus_err_o = 1, HALT. Repeat with ack on the 4th cycle -> normal DECODE, no error.
5. RESET_PC = 32'hFFFF_FFFC, one legal instruction -> pc_o wraps to 0.
6. rst_i asserted in EXECUTE with run_i = 1 -> next cycle state_o = 0, rf_we_o never pulses, instret_o = 0.
